// File: rtl/vrf_port_sched_pkg.sv
// Shared types and default sizes for the vector register file port scheduler.
// Package name is kept as cellrv32_package because other blocks already import it.
package cellrv32_package;

  localparam int DEF_NWB          = 2;
  localparam int DEF_ELEMENTS     = 4;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_VREGS        = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam int VREG_AW = $clog2(DEF_VREGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } sched_state_t;

  typedef logic [DEF_ELEMENTS-1:0][DEF_DATA_WIDTH-1:0] vreg_row_t;

endpackage

// File: rtl/vrf_port_sched_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to winner+1 when the grant is actually taken (advance_i).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr <= '0;
    end else if (advance_i && found) begin
      ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/vrf_port_sched.sv
// Schedules VRF port A / read port 2 between writeback requesters and operand fetch,
// turning masked writebacks into read-modify-write. Optional: VRF_SCHED_STARVE_GUARD_EN.
module vrf_port_sched
  import cellrv32_package::*;
#(
  parameter int NWB          = DEF_NWB,
  parameter int ELEMENTS     = DEF_ELEMENTS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VREGS        = DEF_VREGS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                                          clk_i,
  input  logic                                          rstn_i,
  input  logic [NWB-1:0]                                wb_req_i,
  input  logic [NWB-1:0][$clog2(VREGS)-1:0]             wb_addr_i,
  input  logic [NWB-1:0][ELEMENTS-1:0]                  wb_mask_i,
  input  logic [NWB-1:0][ELEMENTS*DATA_WIDTH-1:0]       wb_data_i,
  output logic [NWB-1:0]                                wb_gnt_o,
  input  logic                                          rd_req_i,
  input  logic [$clog2(VREGS)-1:0]                      rd_addr1_i,
  input  logic [$clog2(VREGS)-1:0]                      rd_addr2_i,
  output logic                                          rd_gnt_o,
  output logic                                          rd_valid_o,
  output logic [ELEMENTS*DATA_WIDTH-1:0]                rd_data1_o,
  output logic [ELEMENTS*DATA_WIDTH-1:0]                rd_data2_o,
  output logic                                          busy_o,
  output logic [$clog2(VREGS)-1:0]                      vrf_rd_addr_1_o,
  output logic [$clog2(VREGS)-1:0]                      vrf_rd_addr_2_o,
  output logic [ELEMENTS-1:0]                           vrf_wr_en_o,
  output logic [$clog2(VREGS)-1:0]                      vrf_wr_addr_o,
  output logic [ELEMENTS*DATA_WIDTH-1:0]                vrf_wr_data_o,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]                vrf_data_out_1_i,
  input  logic [ELEMENTS*DATA_WIDTH-1:0]                vrf_data_out_2_i
);

  localparam int AW = $clog2(VREGS);
  localparam int RW = ELEMENTS * DATA_WIDTH;

  sched_state_t         state;
  logic [AW-1:0]        lat_addr;
  logic [ELEMENTS-1:0]  lat_mask;
  logic [RW-1:0]        lat_data;
  logic [AW-1:0]        rd_addr1_q, rd_addr2_q, wr_addr_q;
  logic [RW-1:0]        wr_data_q;
  logic                 rd_valid_q;

  logic                 idle, any_wb, starve_hit, write_win, read_win;
  logic                 full_wr, part_wr;
  logic [NWB-1:0]       arb_gnt;
  logic [AW-1:0]        sel_addr;
  logic [ELEMENTS-1:0]  sel_mask;
  logic [RW-1:0]        sel_data, merged;

  assign idle   = rstn_i && (state == IDLE);
  assign any_wb = |wb_req_i;

`ifdef VRF_SCHED_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  assign starve_hit = rd_req_i && (starve_cnt == CW'(STARVE_LIMIT));

  // Counts IDLE cycles where a pending read lost to a write; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (read_win) begin
      starve_cnt <= '0;
    end else if (idle && rd_req_i && (starve_cnt != CW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign write_win = idle && any_wb && !starve_hit;
  assign read_win  = idle && rd_req_i && (!any_wb || starve_hit);

  rr_arbiter #(.N(NWB)) u_arb (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (wb_req_i),
    .advance_i (write_win),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_mask = '0;
    sel_data = '0;
    for (int i = 0; i < NWB; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = wb_addr_i[i];
        sel_mask = wb_mask_i[i];
        sel_data = wb_data_i[i];
      end
    end
  end

  assign full_wr = write_win && (&sel_mask);
  assign part_wr = write_win && (|sel_mask) && !(&sel_mask);

  always_comb begin
    merged = vrf_data_out_1_i;
    for (int e = 0; e < ELEMENTS; e++) begin
      if (lat_mask[e]) merged[e*DATA_WIDTH +: DATA_WIDTH] = lat_data[e*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wb_gnt_o   = write_win ? arb_gnt : '0;
  assign rd_gnt_o   = read_win;
  assign busy_o     = rstn_i && (state != IDLE);
  assign rd_valid_o = rstn_i && rd_valid_q;
  assign rd_data1_o = rd_valid_o ? vrf_data_out_1_i : '0;
  assign rd_data2_o = rd_valid_o ? vrf_data_out_2_i : '0;

  // Register-file side: drive only what the current cycle uses, otherwise hold the last value.
  always_comb begin
    vrf_wr_en_o     = '0;
    vrf_wr_addr_o   = wr_addr_q;
    vrf_wr_data_o   = wr_data_q;
    vrf_rd_addr_1_o = rd_addr1_q;
    vrf_rd_addr_2_o = rd_addr2_q;
    if (!rstn_i) begin
      vrf_wr_addr_o   = '0;
      vrf_wr_data_o   = '0;
      vrf_rd_addr_1_o = '0;
      vrf_rd_addr_2_o = '0;
    end else if (full_wr) begin
      vrf_wr_en_o   = '1;
      vrf_wr_addr_o = sel_addr;
      vrf_wr_data_o = sel_data;
    end else if (read_win) begin
      vrf_rd_addr_1_o = rd_addr1_i;
      vrf_rd_addr_2_o = rd_addr2_i;
    end else if (state == RMW_RD) begin
      vrf_rd_addr_1_o = lat_addr;
    end else if (state == RMW_WR) begin
      vrf_wr_en_o   = '1;
      vrf_wr_addr_o = lat_addr;
      vrf_wr_data_o = merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_mask   <= '0;
      lat_data   <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_win;
      rd_addr1_q <= vrf_rd_addr_1_o;
      rd_addr2_q <= vrf_rd_addr_2_o;
      wr_addr_q  <= vrf_wr_addr_o;
      wr_data_q  <= vrf_wr_data_o;
      case (state)
        IDLE: begin
          if (part_wr) begin
            lat_addr <= sel_addr;
            lat_mask <= sel_mask;
            lat_data <= sel_data;
            state    <= RMW_RD;
          end
        end
        RMW_RD:  state <= RMW_WR;
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vrf_port_sched.md
Name: vrf_port_sched

Overview:
- Scheduler for the vector register file's shared port A (write, or read port 1) and its read port 2.
- Arbitrates NWB writeback requesters against one operand-fetch requester.
- Converts element-masked writebacks into read-modify-write sequences, because the register file always writes the full row.
- Sits between the vector execution lanes/LSU writeback and the register file instance.

Parameters:
- NWB, 2, number of writeback requesters
- ELEMENTS, 4, elements per vector register
- DATA_WIDTH, 32, bits per element
- VREGS, 32, number of vector registers
- STARVE_LIMIT, 4, consecutive denied read cycles before read priority (optional feature only)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low
- wb_req_i  in  NWB  writeback request per requester
- wb_addr_i  in  NWB x $clog2(VREGS)  destination register
- wb_mask_i  in  NWB x ELEMENTS  element write enables
- wb_data_i  in  NWB x ELEMENTS*DATA_WIDTH  write data
- wb_gnt_o  out  NWB  one-hot; request consumed this cycle
- rd_req_i  in  1  operand read request
- rd_addr1_i, rd_addr2_i  in  $clog2(VREGS) each  source registers
- rd_gnt_o  out  1  read accepted this cycle
- rd_valid_o  out  1  operand data valid
- rd_data1_o, rd_data2_o  out  ELEMENTS*DATA_WIDTH  operands
- busy_o  out  1  RMW in progress
- vrf_rd_addr_1_o, vrf_rd_addr_2_o  out  $clog2(VREGS)  to register file
- vrf_wr_en_o  out  ELEMENTS  to register file
- vrf_wr_addr_o  out  $clog2(VREGS)  to register file
- vrf_wr_data_o  out  ELEMENTS*DATA_WIDTH  to register file
- vrf_data_out_1_i, vrf_data_out_2_i  in  ELEMENTS*DATA_WIDTH  registered read data from register file

Behaviour:
- States: IDLE, RMW_RD, RMW_WR.
- Reset:
  - State goes to IDLE; round-robin pointer to 0.
  - All outputs 0: gnt, valid, wr_en, addresses, data, busy.
  - Any latched RMW is dropped. Reset mid-RMW leaves the target register unmodified.
- IDLE arbitration:
  - Any wb_req_i asserted: writes win. Round-robin starts at the pointer; the pointer moves to winner+1 (mod NWB) on each grant.
  - wb_gnt_o[w] is asserted combinationally in the same cycle.
- Full mask (all ones):
  - vrf_wr_en_o is all ones, vrf_wr_addr_o/vrf_wr_data_o come from the winner, same cycle.
  - Latency 0; state stays IDLE.
- Zero mask: granted and discarded. No register-file write, state stays IDLE.
- Partial mask:
  - Grant the request, latch addr/mask/data, go to RMW_RD.
  - RMW_RD: vrf_rd_addr_1_o = latched addr, vrf_wr_en_o = 0. Go to RMW_WR.
  - RMW_WR: per element e, merged[e] = mask[e] ? new[e] : vrf_data_out_1_i[e]. Write merged data with wr_en all ones. Go to IDLE.
  - Total 3 cycles including the grant cycle.
- busy_o = 1 in RMW_RD and RMW_WR. No grants in those states.
- Read grant:
  - Issued in IDLE only, when no wb_req_i is asserted.
  - rd_gnt_o = 1; vrf_rd_addr_1_o/vrf_rd_addr_2_o = rd_addr1_i/rd_addr2_i.
  - rd_valid_o = 1 exactly one cycle later. rd_data1_o/rd_data2_o pass through vrf_data_out_1_i/vrf_data_out_2_i that cycle.
- rd_valid_o is registered from rd_gnt_o. Back-to-back reads give valid every cycle.
- Port A is never read and written in the same cycle. A read granted the cycle after a write to the same register returns the new data.
- rd_data*_o are don't-care when rd_valid_o = 0.
- Address outputs hold their last value when unused. The verification bench checks them only when qualified.

Optional Feature:
- Macro VRF_SCHED_STARVE_GUARD_EN.
- When defined:
  - A saturating counter counts IDLE cycles in which rd_req_i=1 and the read was denied. It clears on rd_gnt_o.
  - When the counter reaches STARVE_LIMIT, the next IDLE cycle grants the read over pending writes, then the counter clears.
- When undefined: writes always have strict priority; the counter and STARVE_LIMIT are unused.

Decomposition:
- Shared package (cellrv32_package):
  - typedef for the scheduler state enum.
  - typedef vreg_row_t = logic [ELEMENTS-1:0][DATA_WIDTH-1:0].
  - constant VREG_AW = $clog2(VREGS).
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant out, pointer update on an advance input. Reusable elsewhere.

Test Plan:
- Single full-mask write: wb_req_i=01, addr 5, mask 1111, data 0x...A5 -> wb_gnt_o=01 same cycle, vrf_wr_en_o=1111, addr 5. A read of r5 granted next cycle -> rd_valid_o one cycle later with 0x...A5.
- Partial mask: r3 preloaded 0x44443333_22221111 pattern; write mask 0101, data all 0xFFFFFFFF -> busy_o 2 cycles; written row has elements 0 and 2 = 0xFFFFFFFF, elements 1 and 3 unchanged.
- Contention: wb_req_i=11 held 4 cycles, full masks -> grants alternate 01,10,01,10. rd_req_i held throughout gets no grant (guard off).
- Starve guard on, STARVE_LIMIT=4: writes continuous with rd_req_i held -> rd_gnt_o in the 5th cycle, then writes resume.
- Reset mid-RMW: assert rstn_i=0 in RMW_RD -> next cycle all outputs 0, state IDLE, no write to the target register.
- Zero mask write -> wb_gnt_o pulses, vrf_wr_en_o stays 0, a pending read is granted the next cycle.
